// File: rtl/uart_tx_scheduler_if.sv
// Bundle of request, UART TX handshake and status signals around uart_tx_scheduler.
// The scheduler connects through the slave modport; sources and the TX core sit on the master side.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_pulse;
    logic [8*NUM_REQ-1:0] req_data;
    logic                 tx_busy;
    logic                 ovf_clr;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [2:0]           grant_id;
    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   overflow;
    logic                 timeout_err;

    modport master (
        output req_pulse, req_data, tx_busy, ovf_clr,
        input  tx_start, tx_data, grant_id, pending, overflow, timeout_err
    );

    modport slave (
        input  req_pulse, req_data, tx_busy, ovf_clr,
        output tx_start, tx_data, grant_id, pending, overflow, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ one-shot byte requesters.
// Optional macro SCHED_TERM_EN appends TERM_CHAR after every granted byte.
module uart_tx_scheduler #(
    parameter int         NUM_REQ      = 4,
    parameter int         BUSY_TIMEOUT = 16,
    parameter logic [7:0] TERM_CHAR    = 8'h0D
) (
    input  logic               clock,
    input  logic               n_reset,
    uart_tx_scheduler_if.slave sched
);
    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

`ifdef SCHED_TERM_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        WAIT_BUSY  = 3'd2,
        WAIT_DONE  = 3'd3,
        TERM_START = 3'd4,
        TERM_WAIT  = 3'd5
    } state_t;
    logic busy_seen_q, busy_seen_d;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3
    } state_t;
    logic unused_term_s;
    assign unused_term_s = ^TERM_CHAR;
`endif

    state_t             state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] ovf_q, ovf_d;
    logic [7:0]         hold_q [NUM_REQ];

    logic [2:0]         winner_s;
    logic               grant_s;
    logic [NUM_REQ-1:0] clr_s, ovf_set_s, take_s;
    logic [7:0]         win_byte_s;

    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] pend, input logic [2:0] ptr);
        logic [7:0] pend8;
        logic [3:0] idx;
        logic       found;
        logic [2:0] pick;
        pend8 = 8'(pend);
        found = 1'b0;
        pick  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = {1'b0, ptr} + 4'(k);
            idx   = (idx >= 4'(NUM_REQ)) ? (idx - 4'(NUM_REQ)) : idx;
            pick  = (!found && pend8[idx[2:0]]) ? idx[2:0] : pick;
            found = found | pend8[idx[2:0]];
        end
        return pick;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] w);
        logic [3:0] n;
        n = {1'b0, w} + 4'd1;
        return (n >= 4'(NUM_REQ)) ? 3'd0 : n[2:0];
    endfunction

    assign winner_s = rr_pick(pending_q, rr_ptr_q);
    assign grant_s  = (state_q == IDLE) && (|pending_q);
    assign clr_s    = grant_s ? (NUM_REQ'(1) << winner_s) : {NUM_REQ{1'b0}};

    // A pulse on a flag being granted this cycle re-arms it rather than overflowing.
    assign ovf_set_s = sched.req_pulse & pending_q & ~clr_s;
    assign take_s    = sched.req_pulse & ~ovf_set_s;
    assign pending_d = take_s | (pending_q & ~clr_s);
    assign ovf_d     = ovf_set_s | (sched.ovf_clr ? {NUM_REQ{1'b0}} : ovf_q);

    // Select the winner's held byte.
    always_comb begin
        win_byte_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_byte_s = win_byte_s | (hold_q[i] & {8{winner_s == 3'(i)}});
        end
    end

    // Next-state and registered-output decode; the counter counts cycles since tx_start.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = {CNT_W{1'b0}};
`ifdef SCHED_TERM_EN
        busy_seen_d = busy_seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    tx_data_d  = win_byte_s;
                    grant_d    = winner_s;
                    rr_ptr_d   = rr_next(winner_s);
                    tx_start_d = 1'b1;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sched.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!sched.tx_busy) begin
`ifdef SCHED_TERM_EN
                    tx_data_d  = TERM_CHAR;
                    tx_start_d = 1'b1;
                    state_d    = TERM_START;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = WAIT_DONE;
                end
            end
`ifdef SCHED_TERM_EN
            TERM_START: begin
                cnt_d       = cnt_q + CNT_W'(1);
                busy_seen_d = 1'b0;
                state_d     = TERM_WAIT;
            end
            TERM_WAIT: begin
                if (busy_seen_q) begin
                    if (!sched.tx_busy) begin
                        state_d = IDLE;
                    end else begin
                        state_d = TERM_WAIT;
                    end
                end else if (sched.tx_busy) begin
                    busy_seen_d = 1'b1;
                    state_d     = TERM_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = TERM_WAIT;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 3'd0;
            grant_q    <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            pending_q  <= {NUM_REQ{1'b0}};
            ovf_q      <= {NUM_REQ{1'b0}};
`ifdef SCHED_TERM_EN
            busy_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
`ifdef SCHED_TERM_EN
            busy_seen_q <= busy_seen_d;
`endif
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
        // Per-requester byte holding register, loaded only when the pulse is accepted.
        always_ff @(posedge clock or negedge n_reset) begin
            if (!n_reset) begin
                hold_q[gi] <= 8'h00;
            end else if (take_s[gi]) begin
                hold_q[gi] <= sched.req_data[8*gi +: 8];
            end else begin
                hold_q[gi] <= hold_q[gi];
            end
        end
    end

    assign sched.tx_start    = tx_start_q;
    assign sched.tx_data     = tx_data_q;
    assign sched.grant_id    = grant_q;
    assign sched.pending     = pending_q;
    assign sched.overflow    = ovf_q;
    assign sched.timeout_err = timeout_q;
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter among NUM_REQ event sources, e.g. debounced button pulses or loopback-echo requests.
- Each source raises a one-cycle request pulse with a data byte. The block latches it as pending.
- A round-robin arbiter issues bytes one at a time to the UART TX, using a start/busy handshake.
- Sits between the button-conditioning blocks / RX path and the UART TX core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, max cycles to wait for tx_busy to rise after tx_start.
- TERM_CHAR, 8'h0D, terminator byte sent after every byte when SCHED_TERM_EN is defined.

Ports:
- clock  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- req_pulse  input  NUM_REQ  one-cycle request strobe per requester.
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i], sampled with req_pulse[i].
- tx_busy  input  1  UART TX busy; high while a frame is shifting out.
- tx_start  output  1  one-cycle start strobe to UART TX.
- tx_data  output  8  byte to transmit; stable from tx_start until the handshake ends.
- grant_id  output  3  index of the requester currently or last served.
- pending  output  NUM_REQ  per-requester pending flags.
- overflow  output  NUM_REQ  sticky flag: a request arrived while already pending.
- ovf_clr  input  1  clears all overflow bits.
- timeout_err  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Behaviour:
- Reset values: tx_start=0, tx_data=0, grant_id=0, pending=0, overflow=0, timeout_err=0, state=IDLE, rr pointer=0 (requester 0 has highest priority first), timeout counter=0.
- Pending latch:
  - req_pulse[i] with pending[i]=0 sets pending[i] and captures the byte into a per-requester holding register.
  - req_pulse[i] with pending[i]=1 drops the new byte, keeps the old byte, and sets overflow[i].
  - overflow bits stay set until ovf_clr=1. If ovf_clr and a new overflow occur in the same cycle, the overflow bit ends set.
- Arbitration: round-robin. Search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, plus TERM_START and TERM_WAIT only with SCHED_TERM_EN.
- IDLE, when any pending bit is set:
  - Register tx_data from the winner's holding register and set grant_id = winner.
  - Clear pending[winner] and advance the rr pointer. Go to START.
- START: tx_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 goes to WAIT_DONE.
  - Otherwise the counter increments. When counter == BUSY_TIMEOUT-1, pulse timeout_err for one cycle, abandon the byte (no retry) and go to IDLE.
- WAIT_DONE: tx_busy=0 goes to IDLE.
- Latency: a req_pulse sampled at edge N while the block is IDLE with nothing else pending gives tx_start high during the cycle after edge N+1.
- Back-to-back issue: minimum gap between successive tx_start pulses is the frame duration plus 2 cycles.
- Simultaneous events:
  - req_pulse[winner] in the same cycle the winner is granted: pending is re-set with the new byte, no overflow.
  - All requesters pulsing at once: all are served in rr order starting from the pointer.
- tx_busy already high in IDLE is ignored; the START/WAIT_BUSY handshake handles it. tx_busy high in WAIT_BUSY is accepted immediately.
- Reset mid-transfer: everything returns to reset values immediately and pending bytes are discarded. The UART TX is not aborted.

Optional Feature:
- Macro: SCHED_TERM_EN.
- Defined: WAIT_DONE exits to TERM_START instead of IDLE.
  - TERM_START sets tx_data=TERM_CHAR and pulses tx_start for one cycle.
  - TERM_WAIT then runs the same busy-rise/timeout and busy-fall handshake, then goes to IDLE.
  - grant_id is unchanged during the terminator.
  - A timeout during the terminator pulses timeout_err and goes to IDLE.
- Undefined: the terminator states are absent and exactly one byte is sent per grant.

Test Plan:
- Single request: req_pulse=4'b0010, req_data[15:8]=8'h41 → tx_start two cycles later, tx_data=8'h41, grant_id=1. A tx_busy model held high for 20 cycles, then returned low, brings the FSM to IDLE. pending=0.
- Round-robin: all four pulse the same cycle with bytes 8'h30..8'h33 → tx_data order 30,31,32,33. A second burst with pointer at 0 repeats in the same order. No overflow.
- Overflow: req0 pulses 8'h55, then 8'h66 before being granted → only 8'h55 is transmitted, overflow=4'b0001. ovf_clr → overflow=0.
- Timeout: tx_busy held low → timeout_err pulses exactly 16 cycles after tx_start. FSM returns to IDLE and the next pending byte is served.
- Reset mid-WAIT_DONE with two requests pending → all outputs take reset values and no tx_start occurs after reset release.
- SCHED_TERM_EN: request 8'h41 → two tx_start pulses, tx_data 8'h41 then 8'h0D, grant_id unchanged.
